// File: rtl/divisor_pkg.sv
// -----------------------------------------------------------------------------
// divisor_pkg
// Shared definitions for the divider dispatcher: default operand width and
// queue depth, and the dispatcher FSM state encoding.
// -----------------------------------------------------------------------------
package divisor_pkg;

   localparam int TAMANYO_DEF = 32;   // operand/result width in bits
   localparam int PROF_DEF    = 4;    // operand queue depth (power of two, >= 2)

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,   // idle, waiting for a queued pair
      ARRANQUE = 2'd1,   // Start held high until the divider reports Done
      LIBERA   = 2'd2,   // Start released, waiting for Done to fall
      ENTREGA  = 2'd3    // result presented until the consumer takes it
   } estado_desp_t;

endpackage

// File: rtl/fifo_operandos.sv
// -----------------------------------------------------------------------------
// fifo_operandos
// PROF-entry queue of {numerator, denominator} pairs.
//   clk, rst_n          : clock, asynchronous active-low reset (empties queue)
//   push, push_num/den  : write request and data; ignored while full
//   pop                 : read request; ignored while empty
//   head_num/head_den   : current head entry (valid while empty=0)
//   full, empty         : queue status, decoded from the pointers only
// A push is visible to the reader one cycle later because empty is derived
// from the registered write pointer; there is no bypass path.
// -----------------------------------------------------------------------------
module fifo_operandos
   import divisor_pkg::*;
#(
   parameter int tamanyo = TAMANYO_DEF,
   parameter int PROF    = PROF_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [tamanyo-1:0] push_num,
   input  logic [tamanyo-1:0] push_den,
   input  logic               pop,
   output logic [tamanyo-1:0] head_num,
   output logic [tamanyo-1:0] head_den,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(PROF);

   // One extra pointer bit separates the full and empty cases when the
   // low (address) bits coincide.
   logic [AW:0]          wr_ptr_q, wr_ptr_d;
   logic [AW:0]          rd_ptr_q, rd_ptr_d;
   logic [2*tamanyo-1:0] mem_q [PROF];
   logic                 do_push;
   logic                 do_pop;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   // Full blocks a push even if a pop frees a slot in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; the pointers alone define the contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {push_num, push_den};
      end
   end

   assign {head_num, head_den} = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/despachador_divisor.sv
// -----------------------------------------------------------------------------
// despachador_divisor
// Queues signed operand pairs and feeds them one at a time to an external
// divider using a Start/Done handshake, then presents the result.
//   CLK, RSTa              : clock, asynchronous active-low reset
//   in_valid/in_ready      : operand pair input handshake (in_num, in_den)
//   Start, Num, Den        : request and operands to the divider
//   Done, Coc, Res         : divider completion and quotient/remainder
//   out_valid/out_ready    : result output handshake
//   out_coc, out_res       : registered quotient/remainder
//   out_div0               : result comes from a zero denominator
// Zero denominators never reach the divider: the result is synthesised
// locally as quotient 0, remainder = numerator.
// -----------------------------------------------------------------------------
module despachador_divisor
   import divisor_pkg::*;
#(
   parameter int tamanyo = TAMANYO_DEF,
   parameter int PROF    = PROF_DEF
)(
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [tamanyo-1:0] in_num,
   input  logic [tamanyo-1:0] in_den,
   output logic               Start,
   output logic [tamanyo-1:0] Num,
   output logic [tamanyo-1:0] Den,
   input  logic               Done,
   input  logic [tamanyo-1:0] Coc,
   input  logic [tamanyo-1:0] Res,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [tamanyo-1:0] out_coc,
   output logic [tamanyo-1:0] out_res,
   output logic               out_div0
);

   estado_desp_t       estado_q, estado_d;
   logic [tamanyo-1:0] num_q, num_d;
   logic [tamanyo-1:0] den_q, den_d;
   logic [tamanyo-1:0] coc_q, coc_d;
   logic [tamanyo-1:0] res_q, res_d;
   logic               div0_q, div0_d;

   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [tamanyo-1:0] head_num;
   logic [tamanyo-1:0] head_den;

   fifo_operandos #(
      .tamanyo (tamanyo),
      .PROF    (PROF)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RSTa),
      .push     (in_valid),
      .push_num (in_num),
      .push_den (in_den),
      .pop      (fifo_pop),
      .head_num (head_num),
      .head_den (head_den),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      estado_d = estado_q;
      num_d    = num_q;
      den_d    = den_q;
      coc_d    = coc_q;
      res_d    = res_q;
      div0_d   = div0_q;
      fifo_pop = 1'b0;

      case (estado_q)
         // out_valid is low by construction here, so a non-empty queue is
         // the only condition for taking the next pair.
         REPOSO: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               num_d    = head_num;
               den_d    = head_den;
               if (head_den != '0) begin
                  estado_d = ARRANQUE;
               end else begin
                  coc_d    = '0;
                  res_d    = head_num;
                  div0_d   = 1'b1;
                  estado_d = ENTREGA;
               end
            end
         end
         ARRANQUE: begin
            if (Done) begin
               coc_d    = Coc;
               res_d    = Res;
               div0_d   = 1'b0;
               estado_d = LIBERA;
            end
         end
         // Wait for the divider to drop Done so the next request cannot be
         // confused with this completion.
         LIBERA: begin
            if (!Done) begin
               estado_d = ENTREGA;
            end
         end
         ENTREGA: begin
            if (out_ready) begin
               estado_d = REPOSO;
            end
         end
         default: estado_d = REPOSO;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         estado_q <= REPOSO;
         num_q    <= '0;
         den_q    <= '0;
         coc_q    <= '0;
         res_q    <= '0;
         div0_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         num_q    <= num_d;
         den_q    <= den_d;
         coc_q    <= coc_d;
         res_q    <= res_d;
         div0_q   <= div0_d;
      end
   end

   // Decoded straight from the state flop so reset clears them at once.
   assign Start     = (estado_q == ARRANQUE);
   assign out_valid = (estado_q == ENTREGA);
   assign in_ready  = !fifo_full;
   assign Num       = num_q;
   assign Den       = den_q;
   assign out_coc   = coc_q;
   assign out_res   = res_q;
   assign out_div0  = div0_q;

endmodule

// File: tb/tb_despachador_divisor.sv
// -----------------------------------------------------------------------------
// tb_despachador_divisor
// Bench for despachador_divisor with a behavioural divider attached.
// -----------------------------------------------------------------------------
module tb_despachador_divisor;

   localparam int W  = 32;
   localparam int NV = 12;

   typedef struct {
      int num;
      int den;
      int coc;
      int res;
      bit div0;
   } vec_t;

   logic         CLK = 1'b0;
   logic         RSTa;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_num, in_den;
   logic         Start;
   logic [W-1:0] Num, Den;
   logic         Done;
   logic [W-1:0] Coc, Res;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_coc, out_res;
   logic         out_div0;

   despachador_divisor #(.tamanyo(W), .PROF(4)) dut (
      .CLK(CLK), .RSTa(RSTa),
      .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
      .Start(Start), .Num(Num), .Den(Den),
      .Done(Done), .Coc(Coc), .Res(Res),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_coc(out_coc), .out_res(out_res), .out_div0(out_div0)
   );

   always #5 CLK = ~CLK;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_results = 0;
   int   n_accepted = 0;
   int   n_starts = 0;
   int   ready_mode;     // 0: hold low, 1: hold high, 2: random
   int   gap_mode;       // 0: back-to-back pushes, 1: random idle cycles
   int   div_lat;
   bit   div_lat_rand;
   vec_t stim_q[$];
   vec_t sb_q[$];
   vec_t vecs[NV];

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: quotient truncated toward zero, remainder = n - q*d.
   function automatic vec_t ref_model(int n, int d);
      vec_t v;
      v.num = n;
      v.den = d;
      if (d == 0) begin
         v.coc = 0; v.res = n; v.div0 = 1'b1;
      end else begin
         v.coc = n / d; v.res = n - v.coc * d; v.div0 = 1'b0;
      end
      return v;
   endfunction

   task automatic wait_results(int target, int budget);
      int c = 0;
      while (n_results < target && c < budget) begin
         @(posedge CLK);
         c++;
      end
      chk("result_timeout", int'(n_results >= target), 1);
   endtask

   // Input driver: feeds stim_q, moves accepted pairs into the scoreboard.
   initial begin
      bit xfer;
      in_valid = 1'b0; in_num = '0; in_den = '0;
      forever begin
         @(negedge CLK);
         xfer = in_valid && in_ready;
         @(posedge CLK); #1;
         if (xfer && RSTa && stim_q.size() > 0) begin
            sb_q.push_back(stim_q.pop_front());
            n_accepted++;
         end
         if (stim_q.size() > 0 && RSTa &&
             (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
            in_valid = 1'b1;
            in_num   = stim_q[0].num;
            in_den   = stim_q[0].den;
         end else begin
            in_valid = 1'b0;
         end
      end
   end

   // Consumer ready generator.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge CLK); #1;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Divider model: latches operands when Start is seen, raises Done after
   // the latency, holds Done until Start falls.
   initial begin
      int   dstate, cnt, l_num, l_den;
      logic s_start;
      int   s_num, s_den;
      Done = 1'b0; Coc = '0; Res = '0; dstate = 0; cnt = 0; l_num = 0; l_den = 0;
      forever begin
         @(negedge CLK);
         s_start = Start; s_num = Num; s_den = Den;
         @(posedge CLK); #1;
         if (!RSTa) begin
            dstate = 0; Done = 1'b0;
         end else begin
            case (dstate)
               0: if (s_start) begin
                  chk("start_den_nonzero", int'(s_den != 0), 1);
                  l_num = s_num; l_den = s_den;
                  cnt = div_lat_rand ? int'($urandom_range(1, 8)) : div_lat;
                  dstate = 1;
               end
               1: begin
                  chk("start_held", int'(s_start), 1);
                  chk("num_stable", s_num, l_num);
                  chk("den_stable", s_den, l_den);
                  cnt--;
                  if (cnt <= 1) begin
                     Done = 1'b1;
                     Coc  = (l_den != 0) ? l_num / l_den : 0;
                     Res  = (l_den != 0) ? l_num % l_den : 0;
                     dstate = 2;
                  end
               end
               default: begin
                  chk("num_stable_done", s_num, l_num);
                  chk("den_stable_done", s_den, l_den);
                  if (!s_start) begin
                     Done = 1'b0; dstate = 0;
                  end
               end
            endcase
         end
      end
   end

   // Output monitor.
   logic done_prev = 1'b0, start_prev = 1'b0, park_prev = 1'b0;
   int   coc_prev, res_prev, div0_prev;
   always @(negedge CLK) begin
      vec_t e;
      if (!RSTa) begin
         done_prev = 1'b0; start_prev = 1'b0; park_prev = 1'b0;
      end else begin
         if (done_prev) chk("start_low_after_done", int'(Start), 0);
         if (Start && !start_prev) n_starts++;
         if (park_prev) begin
            chk("parked_valid", int'(out_valid), 1);
            chk("parked_coc", out_coc, coc_prev);
            chk("parked_res", out_res, res_prev);
            chk("parked_div0", int'(out_div0), div0_prev);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = sb_q.pop_front();
               $display("result %0d: %0d / %0d -> coc %0d res %0d div0 %0d",
                        n_results, e.num, e.den, int'(out_coc), int'(out_res), out_div0);
               chk("out_coc", out_coc, e.coc);
               chk("out_res", out_res, e.res);
               chk("out_div0", int'(out_div0), int'(e.div0));
            end
            n_results++;
         end
         done_prev  = Done;
         start_prev = Start;
         park_prev  = out_valid && !out_ready;
         coc_prev   = out_coc;
         res_prev   = out_res;
         div0_prev  = out_div0;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int r0, s0, a0, busy, c;
      vecs[0]  = '{15, 3, 5, 0, 1'b0};
      vecs[1]  = '{-23, -5, 4, -3, 1'b0};
      vecs[2]  = '{17, -3, -5, 2, 1'b0};
      vecs[3]  = '{-17, 3, -5, -2, 1'b0};
      vecs[4]  = '{7, 0, 0, 7, 1'b1};
      vecs[5]  = '{0, 5, 0, 0, 1'b0};
      vecs[6]  = '{-7, 0, 0, -7, 1'b1};
      vecs[7]  = '{100, 7, 14, 2, 1'b0};
      vecs[8]  = '{-100, 7, -14, -2, 1'b0};
      vecs[9]  = '{1, -1, -1, 0, 1'b0};
      vecs[10] = '{-2147483647, 2, -1073741823, -1, 1'b0};
      vecs[11] = '{5, 9, 0, 5, 1'b0};

      RSTa = 1'b0; ready_mode = 0; gap_mode = 0; div_lat = 5; div_lat_rand = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_start", int'(Start), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_num", Num, 0);
      chk("rst_den", Den, 0);
      chk("rst_out_coc", out_coc, 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_out_div0", int'(out_div0), 0);
      RSTa = 1'b1;
      @(posedge CLK); #1;
      chk("in_ready_after_reset", int'(in_ready), 1);

      // Single division, 5-cycle divider.
      ready_mode = 1;
      s0 = n_starts; r0 = n_results;
      stim_q.push_back(vecs[0]);
      wait_results(r0 + 1, 100);
      chk("single_start_train", n_starts - s0, 1);

      // Remaining table vectors back-to-back.
      r0 = n_results; s0 = n_starts;
      for (int i = 1; i < NV; i++) stim_q.push_back(vecs[i]);
      wait_results(r0 + NV - 1, 600);
      chk("table_start_count", n_starts - s0, NV - 3);

      // Consumer stalled: result parks, queue fills, sixth pair waits.
      ready_mode = 0; div_lat = 3;
      r0 = n_results; a0 = n_accepted;
      for (int i = 0; i < 6; i++) stim_q.push_back(ref_model(30 + i, (i == 2) ? 0 : i - 3 + (i >= 3 ? 1 : 0)));
      c = 0;
      while (n_accepted < a0 + 5 && c < 100) begin @(posedge CLK); c++; end
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      chk("stall_accepted", n_accepted - a0, 5);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_no_result", n_results - r0, 0);
      ready_mode = 1;
      wait_results(r0 + 6, 300);
      chk("stall_all_accepted", n_accepted - a0, 6);

      // Randomised traffic.
      ready_mode = 2; gap_mode = 1; div_lat_rand = 1'b1;
      r0 = n_results;
      for (int i = 0; i < 200; i++) begin
         int n, d;
         n = int'($urandom_range(0, 2000000)) - 1000000;
         d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
         stim_q.push_back(ref_model(n, d));
      end
      wait_results(r0 + 200, 8000);

      // Reset while the divider is busy with two pairs queued.
      ready_mode = 1; gap_mode = 0; div_lat_rand = 1'b0; div_lat = 20;
      repeat (5) @(posedge CLK);
      a0 = n_accepted;
      for (int i = 0; i < 3; i++) stim_q.push_back(ref_model(50 + i, 3));
      c = 0;
      while (!(Start && n_accepted >= a0 + 3) && c < 50) begin @(negedge CLK); c++; end
      chk("arranque_reached", int'(Start), 1);
      @(negedge CLK); #2;
      RSTa = 1'b0;
      stim_q.delete(); sb_q.delete(); in_valid = 1'b0;
      #1;
      chk("rst_mid_start", int'(Start), 0);
      chk("rst_mid_out_valid", int'(out_valid), 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RSTa = 1'b1;
      @(posedge CLK); #1;
      chk("rst_mid_in_ready", int'(in_ready), 1);
      r0 = n_results; busy = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (Start || out_valid) busy++;
      end
      chk("no_stale_activity", busy, 0);
      chk("no_stale_result", n_results - r0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/despachador_divisor.md
DESPACHADOR_DIVISOR -- requirements
Module: despachador_divisor

Interface
REQ-001 Parameter tamanyo, default 32: operand/result width in bits, two's-complement signed.
REQ-002 Parameter PROF, default 4: operand queue depth in entries, power of two and at least 2.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RSTa  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered on in_num/in_den.
REQ-006 in_ready  output  1  queue accepts a pair this cycle; transfer happens when in_valid & in_ready.
REQ-007 in_num, in_den  input  tamanyo  signed numerator/denominator.
REQ-008 Start  output  1  start request to the divider.
REQ-009 Num, Den  output  tamanyo  operands presented to the divider.
REQ-010 Done  input  1  divider completion, synchronous to CLK.
REQ-011 Coc, Res  input  tamanyo  divider quotient/remainder, valid while Done=1.
REQ-012 out_valid  output  1  result register holds an unconsumed result.
REQ-013 out_ready  input  1  consumer takes the result when out_valid & out_ready.
REQ-014 out_coc, out_res  output  tamanyo  registered quotient/remainder.
REQ-015 out_div0  output  1  result came from a zero denominator.

Function
REQ-016 The block SHALL buffer pairs in a PROF-entry FIFO; in_ready = not full; a full FIFO rejects a push even when a pop happens in the same cycle.
REQ-017 A pushed pair SHALL become poppable on the next cycle; there is no same-cycle bypass.
REQ-018 The FSM SHALL have states REPOSO, ARRANQUE, LIBERA and ENTREGA.
REQ-019 REPOSO SHALL pop the head when the FIFO is non-empty and out_valid=0, load Num/Den registers, and go to ARRANQUE if Den!=0, otherwise to ENTREGA.
REQ-020 ARRANQUE SHALL drive Start=1 with Num/Den stable.
REQ-021 On the first cycle in ARRANQUE with Done=1, the block SHALL capture Coc/Res into out_coc/out_res, set out_div0=0, and go to LIBERA.
REQ-022 LIBERA SHALL drive Start=0 and wait for Done=0, then go to ENTREGA.
REQ-023 For a zero denominator, ENTREGA entry SHALL load out_coc=0, out_res=the popped numerator and out_div0=1, with Start never asserted.
REQ-024 ENTREGA SHALL hold out_valid=1 with the result stable until out_ready=1, then clear out_valid and return to REPOSO.
REQ-025 Start SHALL be 1 only in ARRANQUE; Num/Den SHALL stay constant from the pop until LIBERA exits.
REQ-026 The block SHALL NOT modify results: quotient truncates toward zero, and the remainder takes the sign of the numerator, as produced by the divider.
REQ-027 The FIFO read/write pointers SHALL be log2(PROF)+1 bits wide, wrapping modulo 2*PROF; full/empty come from MSB difference and low-bit equality.
REQ-028 Pops happen only in REPOSO; pushes are independent of the FSM state.

Reset
REQ-029 RSTa=0 SHALL immediately empty the FIFO, force REPOSO, and clear Start, Num, Den, out_valid, out_coc, out_res and out_div0.
REQ-030 in_ready SHALL be 1 from the first edge after reset release.
REQ-031 Reset mid-operation SHALL discard queued and in-flight pairs; no stale result appears after release.

Structure
REQ-032 The shared package divisor_pkg SHALL hold the FSM state enum (estado_desp_t) and the default tamanyo/PROF constants.
REQ-033 The FIFO SHALL be a sub-module named fifo_operandos, parameterised by tamanyo and PROF, storing {num, den}.

Verification
REQ-034 Push (15,3) with a divider model giving a 5-cycle Done and out_ready=1 -> one Start pulse train ending on Done; out_coc=5, out_res=0, out_div0=0.
REQ-035 Push (-23,-5), (17,-3), (-17,3) back-to-back -> results in order: (4,-3), (-5,2), (-5,-2); Start is never high while Done is high in LIBERA.
REQ-036 Push (7,0) -> Start stays 0; out_valid rises with out_coc=0, out_res=7, out_div0=1.
REQ-037 Hold out_ready=0 and push 6 pairs -> the first result parks; the FIFO then fills with the next 4 pairs; in_ready=0; the 6th pair waits until out_ready=1, with no loss or reordering.
REQ-038 Assert RSTa=0 while in ARRANQUE with 2 pairs queued -> Start and out_valid drop immediately; after release, in_ready=1, the FIFO is empty and no result is emitted.
